// File: rtl/fsm_vedacao_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_vedacao_pkg
// Purpose  : Shared definitions for the sealing-station responder.
//            These are the state encodings, the default 50 MHz time constants
//            and the width of the cork-stock counter.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_vedacao_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VEDANDO   = 2'd1,
    CONCLUIDO = 2'd2,
    SEM_ROLHA = 2'd3
  } estado_t;

  localparam int unsigned CLK_FREQ_HZ       = 50_000_000;
  localparam int unsigned TEMPO_VEDACAO_DEF = CLK_FREQ_HZ;   // 1.0 s actuator pulse
  localparam int unsigned TIMER_W           = 26;            // holds 50e6-1
  localparam int unsigned ESTOQUE_W         = 7;             // 0..99 fits in 7 bits

endpackage
`default_nettype wire

// File: rtl/fsm_vedacao_if.sv
`default_nettype none
// ============================================================================
// Module   : fsm_vedacao_if
// Purpose  : Command/status bundle between the master sequencer and the
//            sealing station.
// Ports    : cmd_vedar, reposicao         - master -> station
//            vedacao_concluida,
//            atuador_vedacao, alarme_rolha,
//            estoque_rolhas               - station -> master / display
// Revision : 1.0 - initial release
// ============================================================================
interface fsm_vedacao_if;
  import fsm_vedacao_pkg::*;

  logic                 cmd_vedar;
  logic                 reposicao;
  logic                 vedacao_concluida;
  logic                 atuador_vedacao;
  logic                 alarme_rolha;
  logic [ESTOQUE_W-1:0] estoque_rolhas;

  modport master (
    output cmd_vedar, reposicao,
    input  vedacao_concluida, atuador_vedacao, alarme_rolha, estoque_rolhas
  );

  modport slave (
    input  cmd_vedar, reposicao,
    output vedacao_concluida, atuador_vedacao, alarme_rolha, estoque_rolhas
  );

endinterface
`default_nettype wire

// File: rtl/fsm_vedacao_contador_rolhas.sv
`default_nettype none
// ============================================================================
// Module   : contador_rolhas
// Purpose  : Cork stock counter. It loads on reset, decrements by one and adds
//            a refill quantity. A decrement and a refill in the same cycle are
//            both applied. The result saturates at ESTOQUE_MAX.
// Ports    : clk, reset_n (async, active-low)
//            dec     - consume one cork
//            add     - add QTD_REPOSICAO corks
//            estoque - current stock
//            zero    - stock is empty
// Revision : 1.0 - initial release
// ============================================================================
module contador_rolhas
  import fsm_vedacao_pkg::*;
#(
  parameter int unsigned ESTOQUE_INICIAL = 20,
  parameter int unsigned QTD_REPOSICAO   = 15,
  parameter int unsigned ESTOQUE_MAX     = 99
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 dec,
  input  wire logic                 add,
  output logic      [ESTOQUE_W-1:0] estoque,
  output logic                      zero
);

  // Two extra bits keep stock + refill from overflowing before saturation.
  localparam int unsigned SOMA_W = ESTOQUE_W + 2;
  typedef logic [SOMA_W-1:0] soma_t;

  localparam soma_t                C_QTD = soma_t'(QTD_REPOSICAO);
  localparam soma_t                C_MAX = soma_t'(ESTOQUE_MAX);
  localparam logic [ESTOQUE_W-1:0] C_INI = ESTOQUE_W'(ESTOQUE_INICIAL);

  logic [ESTOQUE_W-1:0] estoque_q, estoque_d;
  soma_t                soma;

  always_comb begin
    soma = {2'b00, estoque_q};
    if (add) begin
      soma = soma + C_QTD;
    end
    // The FSM never consumes at zero. The guard keeps the counter from
    // wrapping if that ever happened.
    if (dec && (estoque_q != '0)) begin
      soma = soma - soma_t'(1);
    end
    estoque_d = (soma > C_MAX) ? C_MAX[ESTOQUE_W-1:0] : soma[ESTOQUE_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estoque_q <= C_INI;
    end else begin
      estoque_q <= estoque_d;
    end
  end

  assign estoque = estoque_q;
  assign zero    = (estoque_q == '0);

endmodule
`default_nettype wire

// File: rtl/fsm_vedacao.sv
`default_nettype none
// ============================================================================
// Module   : fsm_vedacao
// Purpose  : Sealing-station responder FSM. On cmd_vedar it drives the actuator
//            for TEMPO_VEDACAO cycles and consumes one cork. It then holds
//            vedacao_concluida until the command falls, which completes a
//            4-phase handshake. The block also raises the cork-shortage alarm
//            and accepts refill pulses. All outputs are Moore outputs.
// Ports    : clk     - 50 MHz system clock
//            reset_n - asynchronous active-low reset
//            bus     - fsm_vedacao_if.slave command/status bundle
// Revision : 1.0 - initial release
// ============================================================================
module fsm_vedacao
  import fsm_vedacao_pkg::*;
#(
  parameter int unsigned TEMPO_VEDACAO   = TEMPO_VEDACAO_DEF,
  parameter int unsigned ESTOQUE_INICIAL = 20,
  parameter int unsigned QTD_REPOSICAO   = 15,
  parameter int unsigned ESTOQUE_MAX     = 99
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  fsm_vedacao_if.slave   bus
);

  localparam logic [TIMER_W-1:0] TIMER_FIM = TIMER_W'(TEMPO_VEDACAO - 1);

  estado_t              state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 dec;
  logic                 estoque_zero;
  logic [ESTOQUE_W-1:0] estoque;

  contador_rolhas #(
    .ESTOQUE_INICIAL (ESTOQUE_INICIAL),
    .QTD_REPOSICAO   (QTD_REPOSICAO),
    .ESTOQUE_MAX     (ESTOQUE_MAX)
  ) u_contador (
    .clk     (clk),
    .reset_n (reset_n),
    .dec     (dec),
    .add     (bus.reposicao),
    .estoque (estoque),
    .zero    (estoque_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;          // timer reads zero outside VEDANDO
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_vedar) begin
          state_d = estoque_zero ? SEM_ROLHA : VEDANDO;
        end
      end
      VEDANDO: begin
        // A command that drops before the actuator time elapses aborts the
        // seal without consuming a cork.
        if (!bus.cmd_vedar) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_FIM) begin
          state_d = CONCLUIDO;
          dec     = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CONCLUIDO: begin
        if (!bus.cmd_vedar) begin
          state_d = IDLE;
        end
      end
      SEM_ROLHA: begin
        if (!bus.cmd_vedar) begin
          state_d = IDLE;
        end else if (!estoque_zero) begin
          state_d = VEDANDO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.atuador_vedacao   = (state_q == VEDANDO);
  assign bus.vedacao_concluida = (state_q == CONCLUIDO);
  assign bus.alarme_rolha      = estoque_zero;
  assign bus.estoque_rolhas    = estoque;

endmodule
`default_nettype wire

// File: tb/tb_fsm_vedacao.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_vedacao
// Purpose  : Directed self-checking bench for fsm_vedacao, using TEMPO=4 and
//            an initial stock of 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_vedacao;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  fsm_vedacao_if vif ();

  fsm_vedacao #(
    .TEMPO_VEDACAO   (4),
    .ESTOQUE_INICIAL (2),
    .QTD_REPOSICAO   (15),
    .ESTOQUE_MAX     (99)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input logic act, input logic conc,
                           input logic alm, input int est);
    check({tag, ".atuador"},   32'(vif.atuador_vedacao),   32'(act));
    check({tag, ".concluida"}, 32'(vif.vedacao_concluida), 32'(conc));
    check({tag, ".alarme"},    32'(vif.alarme_rolha),      32'(alm));
    check({tag, ".estoque"},   32'(vif.estoque_rolhas),    32'(est));
  endtask

  // Runs one complete seal with handshake. est_after is the expected stock
  // after the seal.
  task automatic full_cycle(input string tag, input int est_before, input int est_after);
    vif.cmd_vedar = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_out(tag, 1'b1, 1'b0, est_before == 0, est_before);
    end
    tick();
    check_out(tag, 1'b0, 1'b1, est_after == 0, est_after);
    vif.cmd_vedar = 1'b0;
    tick();
    check_out(tag, 1'b0, 1'b0, est_after == 0, est_after);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    vif.cmd_vedar = 1'b0;
    vif.reposicao = 1'b0;

    // Reset state.
    repeat (2) tick();
    check_out("reset", 1'b0, 1'b0, 1'b0, 2);
    reset_n = 1'b1;
    tick();
    check_out("idle", 1'b0, 1'b0, 1'b0, 2);

    // Normal cycle, with concluida held while the command stays high.
    vif.cmd_vedar = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_out("normal.sealing", 1'b1, 1'b0, 1'b0, 2);
    end
    tick();
    check_out("normal.done", 1'b0, 1'b1, 1'b0, 1);
    tick();
    check_out("normal.hold", 1'b0, 1'b1, 1'b0, 1);
    vif.cmd_vedar = 1'b0;
    tick();
    check_out("normal.release", 1'b0, 1'b0, 1'b0, 1);

    // Second seal exhausts the stock.
    full_cycle("exhaust", 1, 0);

    // Command with no stock leads to SEM_ROLHA. The refill then starts sealing.
    vif.cmd_vedar = 1'b1;
    tick();
    check_out("semrolha.enter", 1'b0, 1'b0, 1'b1, 0);
    tick();
    check_out("semrolha.wait", 1'b0, 1'b0, 1'b1, 0);
    vif.reposicao = 1'b1;
    tick();
    vif.reposicao = 1'b0;
    check_out("semrolha.refill", 1'b0, 1'b0, 1'b0, 15);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_out("semrolha.sealing", 1'b1, 1'b0, 1'b0, 15);
    end
    tick();
    check_out("semrolha.done", 1'b0, 1'b1, 1'b0, 14);
    vif.cmd_vedar = 1'b0;
    tick();
    check_out("semrolha.release", 1'b0, 1'b0, 1'b0, 14);

    // Abort after two cycles of sealing.
    vif.cmd_vedar = 1'b1;
    tick();
    tick();
    check_out("abort.sealing", 1'b1, 1'b0, 1'b0, 14);
    vif.cmd_vedar = 1'b0;
    tick();
    check_out("abort.idle", 1'b0, 1'b0, 1'b0, 14);
    repeat (4) tick();
    check_out("abort.quiet", 1'b0, 1'b0, 1'b0, 14);

    // Refills up to saturation: 14 -> 29 -> 44 -> 59 -> 74 -> 89 -> 99.
    for (int i = 1; i <= 6; i++) begin
      vif.reposicao = 1'b1;
      tick();
      vif.reposicao = 1'b0;
      check("sat.refill", 32'(vif.estoque_rolhas), (14 + 15 * i > 99) ? 99 : 14 + 15 * i);
    end
    vif.reposicao = 1'b1;
    tick();
    vif.reposicao = 1'b0;
    check("sat.extra", 32'(vif.estoque_rolhas), 99);

    // A refill on the same edge as the completion decrement gives min(99-1+15, 99).
    vif.cmd_vedar = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    check_out("sat.sealing", 1'b1, 1'b0, 1'b0, 99);
    vif.reposicao = 1'b1;
    tick();
    vif.reposicao = 1'b0;
    check_out("sat.coincident", 1'b0, 1'b1, 1'b0, 99);
    vif.cmd_vedar = 1'b0;
    tick();

    // Asynchronous reset in the middle of a seal.
    vif.cmd_vedar = 1'b1;
    tick();
    tick();
    check_out("areset.before", 1'b1, 1'b0, 1'b0, 99);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("areset.during", 1'b0, 1'b0, 1'b0, 2);
    vif.cmd_vedar = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    check_out("areset.after", 1'b0, 1'b0, 1'b0, 2);
    vif.cmd_vedar = 1'b1;
    tick();
    check("areset.restart", 32'(vif.atuador_vedacao), 1);
    vif.cmd_vedar = 1'b0;
    tick();

    // Drain the stock, enter SEM_ROLHA, then drop the command and refill on
    // the same edge.
    full_cycle("drain1", 2, 1);
    full_cycle("drain2", 1, 0);
    vif.cmd_vedar = 1'b1;
    tick();
    check_out("semidle.enter", 1'b0, 1'b0, 1'b1, 0);
    vif.cmd_vedar = 1'b0;
    vif.reposicao = 1'b1;
    tick();
    vif.reposicao = 1'b0;
    check_out("semidle.refill", 1'b0, 1'b0, 1'b0, 15);
    repeat (3) begin
      tick();
      check_out("semidle.quiet", 1'b0, 1'b0, 1'b0, 15);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
